// File: rtl/adr_fetch_pkg.sv
// ADR core shared fetch definitions.
// Widths, reset constants, fetch FSM states and the fetch buffer entry.
package adr_fetch_pkg;

  localparam int PC_LEN   = 32;
  localparam int INST_LEN = 32;

  localparam logic [INST_LEN-1:0] ADR_NOP      = 32'h0000_0013;
  localparam logic [PC_LEN-1:0]   ADR_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } adr_fetch_state_e;

  typedef struct packed {
    logic [PC_LEN-1:0]   pc;
    logic [INST_LEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_LEN-1:0] pc_align(
    input logic [PC_LEN-1:0] pc
  );
    return pc & {{(PC_LEN-2){1'b1}}, 2'b00};
  endfunction

  // Sequential PC; the carry out of the top bit is dropped.
  function automatic logic [PC_LEN-1:0] pc_next(
    input logic [PC_LEN-1:0] pc
  );
    return pc + PC_LEN'(4);
  endfunction

endpackage

// File: rtl/adr_fetch_buf.sv
// ADR fetch buffer: small FIFO of {pc, inst} entries feeding decode.
// Flush wins over push and pop in the same cycle.
module adr_fetch_buf
  import adr_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update, flush clears everything.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = inc(rd_q);
      if (do_push) wr_d = inc(wr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only read while occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/adr_fetch.sv
// ADR instruction fetch stage: PC, imem req/gnt/rvalid, decode handshake.
// Stale responses after a redirect are counted and dropped in DRAIN.
module adr_fetch
  import adr_fetch_pkg::*;
#(
  parameter logic [PC_LEN-1:0] RESET_PC  = ADR_RESET_PC,
  parameter int                MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                if_imem_req_o,
  output logic [PC_LEN-1:0]   if_imem_addr_o,
  input  logic                imem_if_gnt_i,
  input  logic                imem_if_rvalid_i,
  input  logic [INST_LEN-1:0] imem_if_rdata_i,
  output logic                if_de_valid_o,
  input  logic                de_if_ready_i,
  output logic [INST_LEN-1:0] if_de_inst_o,
  output logic [PC_LEN-1:0]   if_de_pc_o,
  input  logic                ex_if_redirect_i,
  input  logic [PC_LEN-1:0]   ex_if_redirect_pc_i
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int OW = CW + 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  adr_fetch_state_e state_q, state_d;

  logic [PC_LEN-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d, outst_nx;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     discard_left, discard_rd;

  logic [PC_LEN-1:0] tag_q [MAX_OUTST];
  logic [PW-1:0]     tag_rd_q, tag_rd_d;
  logic [PW-1:0]     tag_wr_q, tag_wr_d;

  logic          fire, rsp_ok, drain_hit, pop;
  logic [OW-1:0] occ;

  logic          buf_push, buf_full, buf_empty;
  logic [CW-1:0] buf_count;
  fetch_entry_t  buf_head, buf_data;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign buf_data = '{pc: tag_q[tag_rd_q], inst: imem_if_rdata_i};

  adr_fetch_buf #(
    .DEPTH (MAX_OUTST)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (buf_push),
    .pop_i   (pop),
    .flush_i (ex_if_redirect_i),
    .data_i  (buf_data),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count),
    .head_o  (buf_head)
  );

  assign if_imem_addr_o = pc_q;
  assign if_de_valid_o  = !buf_empty;
  assign if_de_inst_o   = buf_empty ? ADR_NOP : buf_head.inst;
  assign if_de_pc_o     = buf_empty ? '0 : buf_head.pc;

  // Next-state, issue gating, counters; redirect overrides all else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    buf_push   = 1'b0;
    if_imem_req_o = 1'b0;

    pop       = !buf_empty && de_if_ready_i;
    // A pop this cycle frees a slot before any new response can land.
    occ       = OW'(outst_q) + OW'(buf_count) - OW'(pop);
    rsp_ok    = imem_if_rvalid_i && (state_q != DRAIN)
                && (outst_q != '0);
    drain_hit = imem_if_rvalid_i && (state_q == DRAIN)
                && (discard_q != '0);

    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN:   if_imem_req_o = !ex_if_redirect_i
                             && (occ < OW'(MAX_OUTST));
      DRAIN: if (drain_hit && discard_q == CW'(1)) state_d = RUN;
      default: state_d = BOOT;
    endcase

    fire         = if_imem_req_o && imem_if_gnt_i;
    outst_nx     = outst_q + CW'(fire) - CW'(rsp_ok);
    discard_left = discard_q - CW'(drain_hit);
    discard_rd   = discard_left + outst_nx;
    outst_d      = outst_nx;
    discard_d    = discard_left;

    if (fire) begin
      pc_d     = pc_next(pc_q);
      tag_wr_d = inc(tag_wr_q);
    end
    if (rsp_ok) begin
      tag_rd_d = inc(tag_rd_q);
      buf_push = 1'b1;
    end

    if (ex_if_redirect_i) begin
      pc_d      = pc_align(ex_if_redirect_pc_i);
      outst_d   = '0;
      discard_d = discard_rd;
      state_d   = (discard_rd != '0) ? DRAIN : RUN;
      tag_rd_d  = '0;
      tag_wr_d  = '0;
      buf_push  = 1'b0;
    end
  end

  // FSM, PC, counters and tag pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      tag_rd_q  <= '0;
      tag_wr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      tag_rd_q  <= tag_rd_d;
      tag_wr_q  <= tag_wr_d;
    end
  end

  // Remember the PC of each granted request until its response.
  always_ff @(posedge clk) begin
    if (fire) tag_q[tag_wr_q] <= pc_q;
  end

  a_rsp_proto: assert property (@(posedge clk) disable iff (reset)
    !(imem_if_rvalid_i && outst_q == '0 && discard_q == '0))
    else $error("adr_fetch: rvalid with nothing outstanding");

  a_no_ovf: assert property (@(posedge clk) disable iff (reset)
    !(buf_push && buf_full && !pop))
    else $error("adr_fetch: fetch buffer overflow");

endmodule

// File: tb/tb_adr_fetch.sv
// Directed bench for adr_fetch with an in-order 1-cycle memory model.
// Expected PCs are queued at stimulus time and popped on decode transfers.
module tb_adr_fetch;
  import adr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, gnt, rvalid, valid, ready, redir;
  logic [31:0] addr, rdata, inst, pc, redir_pc;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        mem_on, sb_on;
  logic [31:0] pend [$];
  logic [31:0] expq [$];
  int          n_run = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  adr_fetch dut (
    .clk                 (clk),
    .reset               (reset),
    .if_imem_req_o       (req),
    .if_imem_addr_o      (addr),
    .imem_if_gnt_i       (gnt),
    .imem_if_rvalid_i    (rvalid),
    .imem_if_rdata_i     (rdata),
    .if_de_valid_o       (valid),
    .de_if_ready_i       (ready),
    .if_de_inst_o        (inst),
    .if_de_pc_o          (pc),
    .ex_if_redirect_i    (redir),
    .ex_if_redirect_pc_i (redir_pc)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0BAD_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_req = req; s_addr = addr; s_valid = valid;
    s_pc = pc; s_inst = inst;
    if (sb_on && valid && ready) begin
      e = expq.pop_front();
      chk("sb_pc", pc, e);
      chk("sb_inst", inst, memf(e));
      if (expq.size() == 0) sb_on = 1'b0;
    end
    if (req && gnt && !reset) pend.push_back(addr);
    @(posedge clk);
    #1;
    rvalid = 1'b0;
    rdata  = '0;
    if (mem_on && !reset && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = memf(pend.pop_front());
    end
  endtask

  task automatic wait_sb(input string tag, input int budget);
    for (int i = 0; i < budget && sb_on; i++) tick();
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      expq.push_back(a);
      a = a + 32'd4;
    end
    sb_on = 1'b1;
  endtask

  initial begin
    reset = 1'b1; gnt = 1'b0; ready = 1'b0; redir = 1'b0;
    redir_pc = '0; rvalid = 1'b0; rdata = '0;
    mem_on = 1'b1; sb_on = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_inst", s_inst, 32'h13);
    chk("rst_pc", s_pc, 32'd0);
    chk("rst_addr", s_addr, 32'd0);

    // Stream
    reset = 1'b0; gnt = 1'b1; ready = 1'b1;
    push_seq(32'h0, 6);
    tick();
    chk("boot_req", 32'(s_req), 32'd0);
    tick();
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, 32'd0);
    tick();
    tick();
    chk("stream_valid0", 32'(s_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_valid", 32'(s_valid), 32'd1);
    end
    wait_sb("stream_sb", 10);

    // Reset with fetches in flight
    mem_on = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("inflight_pre_rst", 32'(pend.size()), 32'd2);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_inst", inst, 32'h13);
    chk("arst_req", 32'(req), 32'd0);
    pend.delete();
    rvalid = 1'b0;
    mem_on = 1'b1;
    tick();
    tick();

    // Backpressure
    reset = 1'b0; ready = 1'b0;
    tick();
    chk("bp_boot_req", 32'(s_req), 32'd0);
    tick();
    chk("bp_req0", s_addr, 32'h0);
    tick();
    chk("bp_req1", s_addr, 32'h4);
    tick();
    chk("bp_req_drop", 32'(s_req), 32'd0);
    chk("bp_valid", 32'(s_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_pc", s_pc, 32'h0);
      chk("bp_hold_inst", s_inst, memf(32'h0));
      chk("bp_hold_req", 32'(s_req), 32'd0);
    end
    push_seq(32'h0, 4);
    ready = 1'b1;
    wait_sb("bp_sb", 20);

    // Redirect with two fetches in flight
    mem_on = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("inflight_pre_redir", 32'(pend.size()), 32'd2);
    redir = 1'b1; redir_pc = 32'h100;
    tick();
    redir = 1'b0; mem_on = 1'b1;
    push_seq(32'h100, 3);
    tick();
    chk("drain_req", 32'(s_req), 32'd0);
    tick();
    chk("drain_req2", 32'(s_req), 32'd0);
    wait_sb("redir_sb", 20);

    // Redirect together with gnt, rvalid and ready
    for (int i = 0; i < 3; i++) tick();
    redir = 1'b1; redir_pc = 32'h102;
    tick();
    chk("simul_rvalid_in", 32'(rvalid), 32'd0);
    chk("simul_req", 32'(s_req), 32'd0);
    redir = 1'b0;
    push_seq(32'h100, 3);
    tick();
    chk("simul_req_next", 32'(s_req), 32'd1);
    chk("simul_addr", s_addr, 32'h100);
    wait_sb("simul_sb", 20);

    // PC wrap
    for (int i = 0; i < 3; i++) tick();
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    expq.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 3);
    tick();
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", s_addr, 32'h0);
    wait_sb("wrap_sb", 20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
